// File: rtl/cr_cddip_support_mc_if.sv
// ---------------------------------------------------------------------------
// cr_cddip_support_mc_if
// Bundles every non-clock/reset signal of cr_cddip_support_mc.
//   master : the CDDIP pipeline/firmware side (drives events and controls)
//   slave  : the supervisory block (drives stall, counts, flags, int/idle/halt)
//
// Event semantics: every *_rx / *_exit / err_clr bit is a one-cycle pulse.
// A bit high at a rising clk edge means exactly one event on that channel.
// There is no backpressure on these pulses; sup_isf_stall is advisory only
// and an event arriving while stalled is still counted.
//
// dbg_state exposes the drain FSM state (RUN=0, DRAIN=1, DRAINED=2).
// ---------------------------------------------------------------------------
interface cr_cddip_support_mc_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 8,
  parameter int NUM_INT = 4
);
  logic [NUM_CH-1:0]       isf_sup_rqe_rx;
  logic [NUM_CH-1:0]       isf_sup_cqe_exit;
  logic [NUM_CH-1:0]       isf_sup_cqe_rx;
  logic [NUM_CH-1:0]       osf_sup_cqe_exit;
  logic [NUM_INT-1:0]      pre_int;
  logic [NUM_INT-1:0]      int_mask;
  logic                    err_int_en;
  logic [NUM_CH-1:0]       err_clr;
  logic                    drain_req;

  logic [NUM_CH-1:0]       sup_isf_stall;
  logic                    drain_ack;
  logic [NUM_CH*CNT_W-1:0] ch_pipe_cnt;
  logic [NUM_CH*CNT_W-1:0] ch_isf_cnt;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       cnt_ovf_err;
  logic [NUM_CH-1:0]       cnt_unf_err;
  logic                    cddip_int;
  logic                    cddip_idle;
  logic                    sup_osf_halt;
  logic [1:0]              dbg_state;

  modport master (
    output isf_sup_rqe_rx, isf_sup_cqe_exit, isf_sup_cqe_rx, osf_sup_cqe_exit,
           pre_int, int_mask, err_int_en, err_clr, drain_req,
    input  sup_isf_stall, drain_ack, ch_pipe_cnt, ch_isf_cnt, ch_busy,
           cnt_ovf_err, cnt_unf_err, cddip_int, cddip_idle, sup_osf_halt,
           dbg_state
  );

  modport slave (
    input  isf_sup_rqe_rx, isf_sup_cqe_exit, isf_sup_cqe_rx, osf_sup_cqe_exit,
           pre_int, int_mask, err_int_en, err_clr, drain_req,
    output sup_isf_stall, drain_ack, ch_pipe_cnt, ch_isf_cnt, ch_busy,
           cnt_ovf_err, cnt_unf_err, cddip_int, cddip_idle, sup_osf_halt,
           dbg_state
  );
endinterface

// File: rtl/cr_cddip_support_mc.sv
// ---------------------------------------------------------------------------
// cr_cddip_support_mc
// Per-channel command tracking and global supervision for the CDDIP pipeline.
// Each channel keeps three saturating counters:
//   pipe : +rqe_rx        -osf_cqe_exit  (commands anywhere in the pipe)
//   isf  : +rqe_rx        -isf_cqe_exit  (commands resident in the ISF)
//   cqe  : +isf_cqe_rx    -osf_cqe_exit  (CQEs in flight to/through OSF)
// Saturation raises sticky per-channel overflow/underflow flags.
// Globals: idle detector, registered interrupt, OSF halt and a drain FSM
// (RUN -> DRAIN -> DRAINED) that stalls every channel while firmware
// quiesces the block.
//
// Ports:
//   clk  : core clock
//   rst  : asynchronous, active-high reset
//   bus  : cr_cddip_support_mc_if.slave (events/controls in, status out)
// ---------------------------------------------------------------------------
module cr_cddip_support_mc #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 8,
  parameter int MAX_OUTSTANDING = 32,
  parameter int IDLE_HOLD       = 4,
  parameter int NUM_INT         = 4,
  parameter bit HALT_ON_ERR     = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  cr_cddip_support_mc_if.slave bus
);

  localparam int                IDLE_W   = $clog2(IDLE_HOLD + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  STALL_TH = CNT_W'(MAX_OUTSTANDING);
  localparam logic [IDLE_W-1:0] IDLE_TH  = IDLE_W'(IDLE_HOLD);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CNT_W-1:0]   r_pipe     [NUM_CH];
  logic [CNT_W-1:0]   r_isf      [NUM_CH];
  logic [CNT_W-1:0]   r_cqe      [NUM_CH];
  logic [CNT_W-1:0]   w_pipe_nxt [NUM_CH];
  logic [CNT_W-1:0]   w_isf_nxt  [NUM_CH];
  logic [CNT_W-1:0]   w_cqe_nxt  [NUM_CH];
  logic [NUM_CH-1:0]  w_ovf_evt;
  logic [NUM_CH-1:0]  w_unf_evt;
  logic [NUM_CH-1:0]  r_ovf;
  logic [NUM_CH-1:0]  r_unf;

  logic [IDLE_W-1:0]  r_idle_cnt;
  logic               r_idle;
  logic               r_int;
  logic               r_halt;

  logic               w_pipe_zero;
  logic               w_all_zero;
  logic               w_quiet;
  logic               w_any_err;
  logic [NUM_INT-1:0] w_int_src;

  // Returns {ovf, unf, next_count}. Simultaneous inc and dec cancel, so
  // neither can flag an error in that case.
  function automatic logic [CNT_W+1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc,
                                                input logic dec);
    logic [CNT_W+1:0] res;
    res = {2'b00, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_MAX) res[CNT_W+1] = 1'b1;
      else                res[CNT_W-1:0] = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) res[CNT_W] = 1'b1;
      else           res[CNT_W-1:0] = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  // Next counts and per-channel error events (any of the three counters).
  always_comb begin
    logic [CNT_W+1:0] w_p;
    logic [CNT_W+1:0] w_i;
    logic [CNT_W+1:0] w_q;
    w_p       = '0;
    w_i       = '0;
    w_q       = '0;
    w_ovf_evt = '0;
    w_unf_evt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_p = cnt_step(r_pipe[c], bus.isf_sup_rqe_rx[c], bus.osf_sup_cqe_exit[c]);
      w_i = cnt_step(r_isf[c],  bus.isf_sup_rqe_rx[c], bus.isf_sup_cqe_exit[c]);
      w_q = cnt_step(r_cqe[c],  bus.isf_sup_cqe_rx[c], bus.osf_sup_cqe_exit[c]);
      w_pipe_nxt[c] = w_p[CNT_W-1:0];
      w_isf_nxt[c]  = w_i[CNT_W-1:0];
      w_cqe_nxt[c]  = w_q[CNT_W-1:0];
      w_ovf_evt[c]  = w_p[CNT_W+1] | w_i[CNT_W+1] | w_q[CNT_W+1];
      w_unf_evt[c]  = w_p[CNT_W]   | w_i[CNT_W]   | w_q[CNT_W];
    end
  end

  // Zero detection uses registered counts only.
  always_comb begin
    w_pipe_zero = 1'b1;
    w_all_zero  = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_pipe[c] != '0) begin
        w_pipe_zero = 1'b0;
        w_all_zero  = 1'b0;
      end
      if (r_isf[c] != '0) w_all_zero = 1'b0;
    end
  end

  assign w_quiet   = w_pipe_zero & ~(|bus.isf_sup_rqe_rx);
  assign w_any_err = |(r_ovf | r_unf);
  assign w_int_src = bus.pre_int & bus.int_mask;

  // Counters and sticky errors. A new error in the same cycle as err_clr
  // keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_pipe[c] <= '0;
        r_isf[c]  <= '0;
        r_cqe[c]  <= '0;
      end
      r_ovf <= '0;
      r_unf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_pipe[c] <= w_pipe_nxt[c];
        r_isf[c]  <= w_isf_nxt[c];
        r_cqe[c]  <= w_cqe_nxt[c];
      end
      r_ovf <= (r_ovf & ~bus.err_clr) | w_ovf_evt;
      r_unf <= (r_unf & ~bus.err_clr) | w_unf_evt;
    end
  end

  // Idle: the counter saturates at IDLE_HOLD after that many quiet cycles;
  // idle asserts on the next quiet cycle and drops right after a busy one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_idle     <= 1'b0;
      r_int      <= 1'b0;
      r_halt     <= 1'b0;
    end else begin
      if (!w_quiet)                r_idle_cnt <= '0;
      else if (r_idle_cnt != IDLE_TH) r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      r_idle <= w_quiet & (r_idle_cnt == IDLE_TH);
      r_int  <= (|w_int_src) | (bus.err_int_en & w_any_err);
      r_halt <= (|bus.pre_int) | (HALT_ON_ERR & w_any_err);
    end
  end

  // Drain FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (bus.drain_req) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.drain_req)  w_state_nxt = ST_RUN;
        else if (w_all_zero) w_state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        // A late event that makes a count nonzero sends us back to DRAIN.
        if (!bus.drain_req)   w_state_nxt = ST_RUN;
        else if (!w_all_zero) w_state_nxt = ST_DRAIN;
      end
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // Outputs
  always_comb begin
    bus.ch_pipe_cnt   = '0;
    bus.ch_isf_cnt    = '0;
    bus.sup_isf_stall = '0;
    bus.ch_busy       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      bus.ch_pipe_cnt[c*CNT_W +: CNT_W] = r_pipe[c];
      bus.ch_isf_cnt[c*CNT_W +: CNT_W]  = r_isf[c];
      bus.sup_isf_stall[c] = (r_pipe[c] >= STALL_TH) | (r_state != ST_RUN);
      bus.ch_busy[c]       = (r_pipe[c] != '0) | (r_isf[c] != '0) |
                             (r_cqe[c] != '0);
    end
  end

  assign bus.drain_ack    = (r_state == ST_DRAINED);
  assign bus.cnt_ovf_err  = r_ovf;
  assign bus.cnt_unf_err  = r_unf;
  assign bus.cddip_int    = r_int;
  assign bus.cddip_idle   = r_idle;
  assign bus.sup_osf_halt = r_halt;
  assign bus.dbg_state    = r_state;

endmodule
